probe_release_sched: RTL and testbench
======================================

Name: probe_release_sched

Overview:
- In-order release scheduler for the probe-side output path of the partitioned hash join.
- Issues a serial number per accepted probe tuple and bounds tuples in flight to MAX_IN_TRANSIT via issue_ready.
- Commands the per-partition store-and-release buffers to emit results strictly in serial-number order.
- Raises a global last flag once every issued tuple has been released.

Parameters:
- NUM_STORAGES, 8, number of store-and-release buffers (one per partition).
- MAX_IN_TRANSIT, 4, maximum probe tuples issued but not yet released; must be ≥1.
- SN_WIDTH, 32, serial-number width; counters wrap modulo 2^SN_WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- issue_valid  in  1  input converter wants to issue one probe tuple this cycle.
- issue_ready  out  1  credit available; an issue occurs when issue_valid && issue_ready.
- issue_sn  out  SN_WIDTH  serial number assigned to the current issue.
- last_probe_seen  in  1  level; final probe tuple has been issued (sampled and made sticky).
- in_is_stored  in  NUM_STORAGES  bit j: buffer j holds the entry whose serial == next_sn (registered in the buffer).
- release_data  out  NUM_STORAGES  one-hot release command, held until acknowledged.
- release_done  in  NUM_STORAGES  bit j: buffer j has handed the released entry downstream (1-cycle pulse).
- next_sn  out  SN_WIDTH  serial number currently awaited for release.
- in_transit  out  $clog2(MAX_IN_TRANSIT+1)  issued-but-unreleased count.
- local_last_processed  in  NUM_STORAGES  per-buffer "all my input drained" flags.
- last_processed  out  1  sticky global completion flag.
- err_multi  out  1  sticky: more than one in_is_stored bit was set while sampled.

Behaviour:
- Reset (async, immediate, any state): state=IDLE; issue_sn=0; next_sn=0; in_transit=0; release_data=0; last_processed=0; err_multi=0; last_seen flag=0.
- Issue side, every cycle, independent of FSM:
  - issue_ready = (in_transit < MAX_IN_TRANSIT) && !last_seen.
  - On an issue: issue_sn increments by 1 (wraps).
- FSM states IDLE, RELEASE, ADVANCE, SETTLE, DONE.
- IDLE:
  - If |in_is_stored: latch sel = lowest set index; go RELEASE. release_data = one-hot(sel) from the next cycle (1-cycle latency).
  - If more than one bit is set, set err_multi; still pick the lowest.
  - Else if last_seen && in_transit==0 && &local_last_processed: go DONE.
- RELEASE:
  - release_data held at one-hot(sel).
  - On release_done[sel]: go ADVANCE.
  - release_done on any other bit is ignored.
- ADVANCE (1 cycle): release_data=0; next_sn += 1 (wraps); in_transit decrements. Then SETTLE.
- SETTLE (1 cycle): in_is_stored is ignored so buffers can re-evaluate against the new next_sn. Then IDLE.
- DONE: last_processed=1 and issue_ready=0; remains until reset.
- in_transit arithmetic: +1 on issue, −1 in ADVANCE, unchanged when both happen in the same cycle. Never exceeds MAX_IN_TRANSIT and never underflows; an underflow attempt is a design error covered by an assertion.
- Serial wrap: issue_sn and next_sn wrap from 2^SN_WIDTH−1 to 0 with no special handling; ordering holds because in_transit ≤ MAX_IN_TRANSIT << 2^SN_WIDTH.
- last_probe_seen is captured into last_seen on the first high cycle. An issue in that same cycle is still accepted.
- Throughput: one release per 4 cycles minimum (IDLE→RELEASE→ADVANCE→SETTLE), given release_done in the first RELEASE cycle.

Test Plan:
- Reset, then 4 issues on consecutive cycles with MAX_IN_TRANSIT=4 → issue_sn 0,1,2,3; in_transit=4; issue_ready=0 on the cycle after the 4th issue.
- in_is_stored=8'b0000_0100 in IDLE → release_data=8'b0000_0100 next cycle. With release_done[2] one cycle later → next_sn 0→1 and in_transit 4→3 at end of ADVANCE; issue_ready=1.
- in_is_stored=8'b0001_0010 → sel=1, err_multi=1 sticky. release_done[4] pulsed while in RELEASE → no state change.
- Issue and ADVANCE in the same cycle with in_transit=2 → in_transit stays 2; issue_sn and next_sn both increment.
- Preload next_sn=issue_sn=32'hFFFF_FFFF, release one tuple → next_sn=0, no glitch on release_data. Then last_probe_seen=1, in_transit=0, local_last_processed=8'hFF → last_processed=1 within 2 cycles; issue_ready=0.
- Assert reset while in RELEASE with in_transit=3 → all outputs return to reset values in the same cycle (before the next clock edge). After deassert, the first issue gets issue_sn=0.

Source files
------------

// File: rtl/probe_release_sched_if.sv
// ============================================================================
// Module   : probe_release_sched_if
// Purpose  : Issue/release handshake bundle between the probe release
//            scheduler and its input converter and store-and-release buffers.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface probe_release_sched_if #(
  parameter int NUM_STORAGES   = 8,
  parameter int MAX_IN_TRANSIT = 4,
  parameter int SN_WIDTH       = 32
);
  localparam int IT_W = $clog2(MAX_IN_TRANSIT + 1);

  logic                    issue_valid;
  logic                    issue_ready;
  logic [SN_WIDTH-1:0]     issue_sn;
  logic                    last_probe_seen;
  logic [NUM_STORAGES-1:0] in_is_stored;
  logic [NUM_STORAGES-1:0] release_data;
  logic [NUM_STORAGES-1:0] release_done;
  logic [SN_WIDTH-1:0]     next_sn;
  logic [IT_W-1:0]         in_transit;
  logic [NUM_STORAGES-1:0] local_last_processed;
  logic                    last_processed;
  logic                    err_multi;

  // Scheduler side.
  modport master (
    input  issue_valid, last_probe_seen, in_is_stored, release_done,
           local_last_processed,
    output issue_ready, issue_sn, release_data, next_sn, in_transit,
           last_processed, err_multi
  );

  // Converter / buffer side.
  modport slave (
    output issue_valid, last_probe_seen, in_is_stored, release_done,
           local_last_processed,
    input  issue_ready, issue_sn, release_data, next_sn, in_transit,
           last_processed, err_multi
  );
endinterface

`default_nettype wire

// File: rtl/probe_release_sched.sv
// ============================================================================
// Module   : probe_release_sched
// Purpose  : In-order release scheduler for the hash-join probe output path;
//            hands out serial numbers and releases results in serial order.
// Revision : 1.0
// ============================================================================
`default_nettype none

module probe_release_sched #(
  parameter int NUM_STORAGES   = 8,
  parameter int MAX_IN_TRANSIT = 4,
  parameter int SN_WIDTH       = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  probe_release_sched_if.master bus
);
  localparam int IT_W = $clog2(MAX_IN_TRANSIT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RELEASE = 3'd1,
    S_ADVANCE = 3'd2,
    S_SETTLE  = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [SN_WIDTH-1:0]     issue_sn_q, issue_sn_d;
  logic [SN_WIDTH-1:0]     next_sn_q, next_sn_d;
  logic [IT_W-1:0]         in_transit_q, in_transit_d;
  logic [NUM_STORAGES-1:0] release_data_q, release_data_d;
  logic                    last_seen_q, last_seen_d;
  logic                    last_processed_q, last_processed_d;
  logic                    err_multi_q, err_multi_d;

  logic                    issue_ready;
  logic                    issue_fire;
  logic                    advance;
  logic                    stored_any;
  logic                    stored_multi;
  logic [NUM_STORAGES-1:0] stored_lowest;

  assign issue_ready = (in_transit_q < IT_W'(MAX_IN_TRANSIT)) && !last_seen_q
                       && (state_q != S_DONE);
  assign issue_fire  = bus.issue_valid && issue_ready;

  // Two's-complement trick isolates the lowest set bit as a one-hot vector.
  assign stored_lowest = bus.in_is_stored & (~bus.in_is_stored + NUM_STORAGES'(1));
  assign stored_any    = |bus.in_is_stored;
  assign stored_multi  = |(bus.in_is_stored & (bus.in_is_stored - NUM_STORAGES'(1)));

  always_comb begin
    state_d          = state_q;
    release_data_d   = release_data_q;
    next_sn_d        = next_sn_q;
    err_multi_d      = err_multi_q;
    last_processed_d = last_processed_q;
    advance          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (stored_any) begin
          release_data_d = stored_lowest;
          err_multi_d    = err_multi_q | stored_multi;
          state_d        = S_RELEASE;
        end else if (last_seen_q && (in_transit_q == '0) && (&bus.local_last_processed)) begin
          last_processed_d = 1'b1;
          state_d          = S_DONE;
        end
      end
      S_RELEASE: begin
        // Only the acknowledge from the commanded buffer counts.
        if (|(bus.release_done & release_data_q)) begin
          release_data_d = '0;
          state_d        = S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        advance   = 1'b1;
        next_sn_d = next_sn_q + SN_WIDTH'(1);
        state_d   = S_SETTLE;
      end
      // Buffers need one cycle to compare against the new next_sn.
      S_SETTLE: state_d = S_IDLE;
      S_DONE:   state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    issue_sn_d   = issue_fire ? issue_sn_q + SN_WIDTH'(1) : issue_sn_q;
    last_seen_d  = last_seen_q | bus.last_probe_seen;
    in_transit_d = in_transit_q;
    case ({issue_fire, advance})
      2'b10:   in_transit_d = in_transit_q + IT_W'(1);
      2'b01:   in_transit_d = (in_transit_q == '0) ? in_transit_q : in_transit_q - IT_W'(1);
      default: in_transit_d = in_transit_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      issue_sn_q       <= '0;
      next_sn_q        <= '0;
      in_transit_q     <= '0;
      release_data_q   <= '0;
      last_seen_q      <= 1'b0;
      last_processed_q <= 1'b0;
      err_multi_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      issue_sn_q       <= issue_sn_d;
      next_sn_q        <= next_sn_d;
      in_transit_q     <= in_transit_d;
      release_data_q   <= release_data_d;
      last_seen_q      <= last_seen_d;
      last_processed_q <= last_processed_d;
      err_multi_q      <= err_multi_d;
    end
  end

  assign bus.issue_ready    = issue_ready;
  assign bus.issue_sn       = issue_sn_q;
  assign bus.next_sn        = next_sn_q;
  assign bus.in_transit     = in_transit_q;
  assign bus.release_data   = release_data_q;
  assign bus.last_processed = last_processed_q;
  assign bus.err_multi      = err_multi_q;

  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    (state_q == S_ADVANCE) |-> (in_transit_q != '0));

endmodule

`default_nettype wire

// File: tb/tb_probe_release_sched.sv
// ============================================================================
// Module   : tb_probe_release_sched
// Purpose  : Directed plus randomized bench for probe_release_sched against a
//            counter/queue model of issue, buffering and in-order release.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_probe_release_sched;
  localparam int NS   = 8;
  localparam int MAXT = 4;
  localparam int SNW  = 5;   // small serial space so the random run wraps
  localparam int SNM  = 1 << SNW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  probe_release_sched_if #(.NUM_STORAGES(NS), .MAX_IN_TRANSIT(MAXT), .SN_WIDTH(SNW)) bus ();

  probe_release_sched #(.NUM_STORAGES(NS), .MAX_IN_TRANSIT(MAXT), .SN_WIDTH(SNW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: totals of issued / released tuples plus buffer contents.
  int  n_iss, n_rel, cyc, cd, wait_cnt, hold;
  bit  done_sent, in_rel, m_last_seen, prev_drove;
  int  part_of    [SNM];
  int  stored_cyc [SNM];

  task automatic rel_one(input logic [7:0] st, input logic [7:0] noise, input bit iss,
                         input int exp_next, input int exp_tr);
    logic [7:0] sel;
    sel = st & (~st + 8'd1);
    bus.in_is_stored = st;
    @(negedge clk);
    chk_val("rel_cmd", 32'(bus.release_data), 32'(sel));
    if (noise != 8'd0) begin
      bus.release_done = noise;
      @(negedge clk);
      bus.release_done = '0;
      chk_val("rel_noise_hold", 32'(bus.release_data), 32'(sel));
      chk_val("rel_noise_sn", 32'(bus.next_sn), 32'(exp_next - 1));
    end
    bus.release_done = sel;
    @(negedge clk);
    bus.release_done = '0;
    bus.in_is_stored = '0;
    bus.issue_valid  = iss;
    chk_val("rel_adv_zero", 32'(bus.release_data), 32'd0);
    @(negedge clk);
    bus.issue_valid = 1'b0;
    chk_val("rel_next_sn", 32'(bus.next_sn), 32'(exp_next));
    chk_val("rel_transit", 32'(bus.in_transit), 32'(exp_tr));
    chk_val("rel_ready", 32'(bus.issue_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic rand_cycle(input bit allow_issue, input bit lastp, input logic [7:0] llp);
    logic [7:0] rd, exp_sel;
    bit         avail, fire;
    rd      = bus.release_data;
    exp_sel = 8'd1 << part_of[n_rel % SNM];

    chk_val("r_issue_sn", 32'(bus.issue_sn), 32'(n_iss % SNM));
    chk_val("r_next_sn", 32'(bus.next_sn), 32'(n_rel % SNM));
    chk_val("r_transit", 32'(bus.in_transit), 32'(n_iss - n_rel));
    chk_val("r_ready", 32'(bus.issue_ready), 32'(((n_iss - n_rel) < MAXT) && !m_last_seen));
    chk_val("r_err_multi", 32'(bus.err_multi), 32'd0);
    chk_val("r_last_proc", 32'(bus.last_processed), 32'd0);

    if (rd != 8'd0) begin
      if (!in_rel) begin
        chk_val("r_rel_latency", 32'(wait_cnt <= 1), 32'd1);
        wait_cnt = 0;
        in_rel   = 1'b1;
        hold     = $urandom_range(0, 2);
      end
      chk_val("r_rel_sel", 32'(rd), (done_sent || n_rel >= n_iss) ? 32'd0 : 32'(exp_sel));
    end else if (prev_drove) begin
      wait_cnt++;
      if (wait_cnt == 2) chk_val("r_rel_latency", 32'(wait_cnt), 32'd1);
    end

    bus.release_done = '0;
    if (rd != 8'd0 && in_rel && !done_sent && rd == exp_sel) begin
      if (hold == 0) begin
        bus.release_done = rd;
        done_sent = 1'b1;
        in_rel    = 1'b0;
        cd        = 2;
      end else begin
        hold--;
        // Acks from other buffers must be ignored.
        if ($urandom_range(0, 3) == 0) bus.release_done = {rd[6:0], rd[7]};
      end
    end

    avail = (n_rel < n_iss) && !done_sent && (cyc >= stored_cyc[n_rel % SNM]);
    bus.in_is_stored = avail ? exp_sel : 8'd0;
    prev_drove = avail;

    bus.issue_valid = allow_issue && ($urandom_range(0, 1) == 1);
    fire = bus.issue_valid && ((n_iss - n_rel) < MAXT) && !m_last_seen;
    if (fire) begin
      part_of[n_iss % SNM]    = $urandom_range(0, NS - 1);
      stored_cyc[n_iss % SNM] = cyc + 1 + $urandom_range(0, 6);
    end
    bus.last_probe_seen      = lastp;
    bus.local_last_processed = llp;

    if (fire) n_iss++;
    if (cd == 1) begin
      n_rel++;
      done_sent = 1'b0;
      cd = 0;
    end else if (cd == 2) begin
      cd = 1;
    end
    if (lastp) m_last_seen = 1'b1;
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    reset                    = 1'b1;
    bus.issue_valid          = 1'b0;
    bus.last_probe_seen      = 1'b0;
    bus.in_is_stored         = '0;
    bus.release_done         = '0;
    bus.local_last_processed = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    chk_val("rst_issue_sn", 32'(bus.issue_sn), 32'd0);
    chk_val("rst_next_sn", 32'(bus.next_sn), 32'd0);
    chk_val("rst_transit", 32'(bus.in_transit), 32'd0);
    chk_val("rst_rel_data", 32'(bus.release_data), 32'd0);
    chk_val("rst_ready", 32'(bus.issue_ready), 32'd1);
    chk_val("rst_last_proc", 32'(bus.last_processed), 32'd0);
    chk_val("rst_err_multi", 32'(bus.err_multi), 32'd0);

    // Fill the credit window.
    bus.issue_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_val("fill_issue_sn", 32'(bus.issue_sn), 32'(i));
      @(negedge clk);
    end
    bus.issue_valid = 1'b0;
    chk_val("fill_transit", 32'(bus.in_transit), 32'd4);
    chk_val("fill_ready_low", 32'(bus.issue_ready), 32'd0);
    chk_val("fill_issue_sn4", 32'(bus.issue_sn), 32'd4);

    rel_one(8'h04, 8'h00, 1'b0, 1, 3);
    chk_val("single_err_multi", 32'(bus.err_multi), 32'd0);
    rel_one(8'h12, 8'h10, 1'b0, 2, 2);
    chk_val("multi_err_sticky", 32'(bus.err_multi), 32'd1);
    rel_one(8'h01, 8'h00, 1'b1, 3, 2);
    chk_val("adv_issue_sn", 32'(bus.issue_sn), 32'd5);
    chk_val("err_multi_kept", 32'(bus.err_multi), 32'd1);

    // Reset while a release is pending.
    bus.issue_valid = 1'b1;
    @(negedge clk);
    bus.issue_valid  = 1'b0;
    chk_val("pre_rst_transit", 32'(bus.in_transit), 32'd3);
    bus.in_is_stored = 8'h08;
    @(negedge clk);
    chk_val("pre_rst_rel", 32'(bus.release_data), 32'h08);
    #3 reset = 1'b1;
    #1;
    chk_val("arst_issue_sn", 32'(bus.issue_sn), 32'd0);
    chk_val("arst_next_sn", 32'(bus.next_sn), 32'd0);
    chk_val("arst_transit", 32'(bus.in_transit), 32'd0);
    chk_val("arst_rel_data", 32'(bus.release_data), 32'd0);
    chk_val("arst_err_multi", 32'(bus.err_multi), 32'd0);
    chk_val("arst_last_proc", 32'(bus.last_processed), 32'd0);
    chk_val("arst_ready", 32'(bus.issue_ready), 32'd1);
    @(negedge clk);
    reset            = 1'b0;
    bus.in_is_stored = '0;
    chk_val("post_rst_sn0", 32'(bus.issue_sn), 32'd0);
    bus.issue_valid = 1'b1;
    @(negedge clk);
    bus.issue_valid = 1'b0;
    chk_val("post_rst_sn1", 32'(bus.issue_sn), 32'd1);
    chk_val("post_rst_transit", 32'(bus.in_transit), 32'd1);

    n_iss = 1; n_rel = 0; cyc = 0; cd = 0; wait_cnt = 0; hold = 0;
    done_sent = 1'b0; in_rel = 1'b0; m_last_seen = 1'b0; prev_drove = 1'b0;
    for (int i = 0; i < SNM; i++) begin
      part_of[i]    = 0;
      stored_cyc[i] = 0;
    end
    part_of[0] = 5;

    for (int i = 0; i < 1500; i++)
      rand_cycle(1'b1, 1'b0, 8'($urandom_range(0, 255)));
    chk_val("wrapped", 32'(n_rel > SNM), 32'd1);

    // Stop issuing and drain; completion held back until all buffers report.
    for (int i = 0; i < 300; i++) begin
      if (n_rel == n_iss && cd == 0 && i > 0) break;
      rand_cycle(1'b0, 1'b1, 8'h7F);
    end
    chk_val("drained", 32'(n_iss - n_rel), 32'd0);
    bus.local_last_processed = 8'hFF;
    bus.in_is_stored         = '0;
    bus.release_done         = '0;
    bus.issue_valid          = 1'b0;
    repeat (2) @(negedge clk);
    chk_val("done_last_proc", 32'(bus.last_processed), 32'd1);
    chk_val("done_ready_low", 32'(bus.issue_ready), 32'd0);
    chk_val("done_transit", 32'(bus.in_transit), 32'd0);
    chk_val("done_next_sn", 32'(bus.next_sn), 32'(n_rel % SNM));
    bus.issue_valid = 1'b1;
    @(negedge clk);
    bus.issue_valid = 1'b0;
    chk_val("done_no_issue", 32'(bus.issue_sn), 32'(n_iss % SNM));
    chk_val("done_sticky", 32'(bus.last_processed), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
